// File: rtl/axi_read_intf.sv
// -----------------------------------------------------------------------------
// axi_read_intf
//   AXI4 read-slave front end. Accepts one AR burst at a time, turns it into
//   per-beat read strobes towards the on-chip RAM/FIFO read ports and returns
//   the data on the R channel through a 2-entry skid buffer with full RREADY
//   back-pressure. Only one burst is outstanding at a time.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   AR*                 AXI read-address channel (ARID/ARADDR/ARLEN/ARSIZE/
//                       ARBURST/ARREGION/ARVALID in, ARREADY out)
//   R*                  AXI read-data channel (RID/RDATA/RRESP/RLAST/RVALID
//                       out, RREADY in)
//   axi_rd_req          one-cycle read strobe to the internal memory
//   axi_rd_addr         byte address of the strobed read
//   axi_rd_region       ARREGION[1:0] of the current burst (0 fifo/1 iram/2 wram)
//   axi_rd_data         memory data, valid RD_LAT cycles after axi_rd_req
//   axi_rd_done         one-cycle pulse on the RLAST handshake
// -----------------------------------------------------------------------------
module axi_read_intf #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int ID_W   = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic [3:0]        ARREGION,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              axi_rd_req,
  output logic [ADDR_W-1:0] axi_rd_addr,
  output logic [1:0]        axi_rd_region,
  input  logic [DATA_W-1:0] axi_rd_data,
  output logic              axi_rd_done
);

  localparam int SIZE_MAX = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Address of the beat following 'addr' for the given burst type.
  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] addr,
    input logic [2:0]        size,
    input logic [1:0]        burst,
    input logic [7:0]        len
  );
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] res;
    step = ADDR_W'(1) << size;
    // WRAP container size minus one; only meaningful for legal WRAP lengths
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      2'b01:   res = addr + step;
      2'b10:   res = (addr & ~mask) | ((addr + step) & mask);
      default: res = addr;
    endcase
    return res;
  endfunction

  // Bursts the slave cannot serve: answered with SLVERR beats, no memory access.
  function automatic logic burst_err(
    input logic [3:0] region,
    input logic [2:0] size,
    input logic [1:0] burst,
    input logic [7:0] len
  );
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (region > 4'd2) || (size > 3'(SIZE_MAX)) || (burst == 2'b11) ||
           ((burst == 2'b10) && !wrap_len_ok);
  endfunction

  // FSM
  state_t r_state;
  state_t w_state_nxt;

  // latched burst attributes
  logic              r_arready;
  logic [ID_W-1:0]   r_id;
  logic [7:0]        r_len;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [1:0]        r_region;
  logic              r_err;

  // issue side: r_cnt/r_addr describe the next beat still to be issued
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_tok;       // a beat is issued this cycle (also for error bursts)
  logic              r_tok_last;
  logic              r_req;
  logic [ADDR_W-1:0] r_rd_addr;

  // one token per issued beat travels RD_LAT cycles alongside the memory read
  logic [RD_LAT-1:0] r_lat;
  logic [RD_LAT-1:0] r_lat_last;

  // skid buffer: head entry drives the R channel, second entry absorbs stalls
  logic              r_h_vld;
  logic [DATA_W-1:0] r_h_data;
  logic [1:0]        r_h_resp;
  logic              r_h_last;
  logic              r_s_vld;
  logic [DATA_W-1:0] r_s_data;
  logic [1:0]        r_s_resp;
  logic              r_s_last;

  logic              w_ar_hs;
  logic              w_err;
  logic              w_pop;
  logic              w_push;
  logic              w_rlast_hs;
  logic [2:0]        w_inflight;
  logic [2:0]        w_occ;
  logic [2:0]        w_proj;
  logic              w_issue;
  logic [DATA_W-1:0] w_push_data;
  logic [1:0]        w_push_resp;

  assign w_ar_hs     = ARVALID & r_arready;
  assign w_err       = burst_err(ARREGION, ARSIZE, ARBURST, ARLEN);
  assign w_pop       = r_h_vld & RREADY;
  assign w_push      = r_lat[RD_LAT-1];
  assign w_rlast_hs  = w_pop & r_h_last;
  assign w_push_data = r_err ? {DATA_W{1'b0}} : axi_rd_data;
  assign w_push_resp = r_err ? 2'b10 : 2'b00;

  // Count tokens issued but not yet landed in the skid buffer.
  always_comb begin
    w_inflight = {2'b00, r_tok};
    for (int k = 0; k < RD_LAT; k++) begin
      w_inflight = w_inflight + {2'b00, r_lat[k]};
    end
  end

  // Credit check: occupancy next cycle (after this cycle's pop) must leave room
  // for one more beat so the 2-entry buffer can never overflow.
  assign w_occ   = w_inflight + {2'b00, r_h_vld} + {2'b00, r_s_vld};
  assign w_proj  = w_occ - {2'b00, w_pop};
  assign w_issue = (r_state == S_BURST) && (w_proj < 3'd2);

  // Next-state logic of the burst FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ar_hs) begin
          // beat 0 is issued on the handshake itself
          if (ARLEN == 8'd0) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_BURST;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BURST: begin
        if (w_issue && (r_cnt == r_len)) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_BURST;
        end
      end
      S_DRAIN: begin
        if (w_rlast_hs) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ARREADY: high whenever the FSM is (or is about to be) idle and no AR is being taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arready <= 1'b0;
    end else if (w_ar_hs) begin
      r_arready <= 1'b0;
    end else begin
      r_arready <= (w_state_nxt == S_IDLE);
    end
  end

  // Burst capture and per-beat issue of memory read strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id       <= '0;
      r_len      <= 8'd0;
      r_size     <= 3'd0;
      r_burst    <= 2'b00;
      r_region   <= 2'b00;
      r_err      <= 1'b0;
      r_cnt      <= 8'd0;
      r_addr     <= '0;
      r_tok      <= 1'b0;
      r_tok_last <= 1'b0;
      r_req      <= 1'b0;
      r_rd_addr  <= '0;
    end else if (w_ar_hs) begin
      r_id       <= ARID;
      r_len      <= ARLEN;
      r_size     <= ARSIZE;
      r_burst    <= ARBURST;
      r_region   <= ARREGION[1:0];
      r_err      <= w_err;
      r_cnt      <= 8'd1;
      r_addr     <= next_addr(ARADDR, ARSIZE, ARBURST, ARLEN);
      r_tok      <= 1'b1;
      r_tok_last <= (ARLEN == 8'd0);
      r_req      <= ~w_err;
      r_rd_addr  <= ARADDR;
    end else if (w_issue) begin
      r_cnt      <= r_cnt + 8'd1;
      r_addr     <= next_addr(r_addr, r_size, r_burst, r_len);
      r_tok      <= 1'b1;
      r_tok_last <= (r_cnt == r_len);
      // error bursts keep the same pacing but never touch memory
      r_req      <= ~r_err;
      r_rd_addr  <= r_addr;
    end else begin
      r_tok      <= 1'b0;
      r_tok_last <= 1'b0;
      r_req      <= 1'b0;
    end
  end

  // Read-latency pipeline: marks the cycle in which axi_rd_data belongs to a beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat      <= '0;
      r_lat_last <= '0;
    end else begin
      r_lat[0]      <= r_tok;
      r_lat_last[0] <= r_tok_last;
      for (int k = 1; k < RD_LAT; k++) begin
        r_lat[k]      <= r_lat[k-1];
        r_lat_last[k] <= r_lat_last[k-1];
      end
    end
  end

  // Skid buffer: push from the latency pipeline, pop on the R handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_vld  <= 1'b0;
      r_h_data <= '0;
      r_h_resp <= 2'b00;
      r_h_last <= 1'b0;
      r_s_vld  <= 1'b0;
      r_s_data <= '0;
      r_s_resp <= 2'b00;
      r_s_last <= 1'b0;
    end else if (w_pop) begin
      if (r_s_vld) begin
        // second entry moves to the head; a concurrent push refills it
        r_h_data <= r_s_data;
        r_h_resp <= r_s_resp;
        r_h_last <= r_s_last;
        if (w_push) begin
          r_s_data <= w_push_data;
          r_s_resp <= w_push_resp;
          r_s_last <= r_lat_last[RD_LAT-1];
        end else begin
          r_s_vld <= 1'b0;
        end
      end else if (w_push) begin
        r_h_data <= w_push_data;
        r_h_resp <= w_push_resp;
        r_h_last <= r_lat_last[RD_LAT-1];
      end else begin
        r_h_vld <= 1'b0;
      end
    end else if (w_push) begin
      if (!r_h_vld) begin
        r_h_vld  <= 1'b1;
        r_h_data <= w_push_data;
        r_h_resp <= w_push_resp;
        r_h_last <= r_lat_last[RD_LAT-1];
      end else begin
        r_s_vld  <= 1'b1;
        r_s_data <= w_push_data;
        r_s_resp <= w_push_resp;
        r_s_last <= r_lat_last[RD_LAT-1];
      end
    end else begin
      r_h_vld <= r_h_vld;
    end
  end

  assign ARREADY       = r_arready;
  assign RID           = r_id;
  assign RDATA         = r_h_data;
  assign RRESP         = r_h_resp;
  assign RLAST         = r_h_last & r_h_vld;
  assign RVALID        = r_h_vld;
  assign axi_rd_req    = r_req;
  assign axi_rd_addr   = r_rd_addr;
  assign axi_rd_region = r_region;
  assign axi_rd_done   = w_rlast_hs;

endmodule

// File: tb/tb_axi_read_intf.sv
// -----------------------------------------------------------------------------
// tb_axi_read_intf
//   Directed bench for axi_read_intf: a table of AR bursts with hand-computed
//   address sequences and responses, a one-cycle-latency memory model, plus
//   hand-written sequences for back-to-back bursts and reset mid-burst.
// -----------------------------------------------------------------------------
module tb_axi_read_intf;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int ID_W   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic [3:0]        ARREGION;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;
  logic              axi_rd_req;
  logic [ADDR_W-1:0] axi_rd_addr;
  logic [1:0]        axi_rd_region;
  logic [DATA_W-1:0] axi_rd_data;
  logic              axi_rd_done;

  always #5 clk = ~clk;

  axi_read_intf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .axi_rd_req(axi_rd_req), .axi_rd_addr(axi_rd_addr), .axi_rd_region(axi_rd_region),
    .axi_rd_data(axi_rd_data), .axi_rd_done(axi_rd_done)
  );

  // Memory model, one cycle latency; garbage when not strobed so mistimed captures show.
  logic [7:0] tag;
  always @(posedge clk) begin
    if (axi_rd_req) axi_rd_data <= {8'hA5, tag, 5'b00000, axi_rd_addr};
    else            axi_rd_data <= 32'hDEADBEEF;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string            name;
    logic [7:0]       id;
    logic [10:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       region;
    logic [1:0]       exp_resp;
    int               exp_nreq;
    logic [7:0][10:0] exp_addr;   // element [i] is beat i
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input string nm, input logic [7:0] id, input logic [10:0] addr,
                              input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                              input logic [3:0] region, input logic [1:0] resp, input int nreq,
                              input logic [7:0][10:0] ea);
    vec_t v;
    v.name = nm; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.region = region; v.exp_resp = resp; v.exp_nreq = nreq; v.exp_addr = ea;
    return v;
  endfunction

  // Runs one burst from the current (post-negedge) point.
  // mode 1: RREADY toggles, held low for cycles 8..12. keep: ARVALID stays high.
  // abort_beats > 0: stop after that many R handshakes (caller resets the DUT).
  task automatic run_vec(input int vi, input int mode, input bit keep, input int abort_beats);
    vec_t v;
    int cyc, beat, nreq, nhs, ndone, first_rv, maxahead;
    bit fin, prev_stall;
    logic [31:0] exp_d, held_d;
    logic [1:0] held_resp;
    logic held_last;
    v = vecs[vi];
    ARID = v.id; ARADDR = v.addr; ARLEN = v.len; ARSIZE = v.size;
    ARBURST = v.burst; ARREGION = v.region; ARVALID = 1'b1;
    cyc = 0;
    while (!ARREADY && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    chk({v.name, ":ar_handshake"}, ARREADY, 1);
    beat = 0; nreq = 0; nhs = 0; ndone = 0; first_rv = -1; maxahead = 0;
    fin = 0; prev_stall = 0; held_d = 0; held_resp = 0; held_last = 0;
    for (int k = 1; k <= 120 && !fin; k++) begin
      @(negedge clk);
      if (k == 1 && !keep) ARVALID = 1'b0;
      if (mode == 1) RREADY = (k >= 8 && k <= 12) ? 1'b0 : k[0];
      else           RREADY = 1'b1;
      #1;
      if (prev_stall) begin
        chk({v.name, ":stall_rvalid"}, RVALID, 1);
        chk({v.name, ":stall_rdata"}, RDATA, held_d);
        chk({v.name, ":stall_rresp"}, RRESP, held_resp);
        chk({v.name, ":stall_rlast"}, RLAST, held_last);
      end
      chk({v.name, ":arready_busy"}, ARREADY, 0);
      if (axi_rd_req) begin
        chk({v.name, ":req_addr"}, axi_rd_addr, (nreq < 8) ? v.exp_addr[nreq] : 11'h7FF);
        chk({v.name, ":req_region"}, axi_rd_region, v.region[1:0]);
        nreq++;
      end
      if (nreq - nhs > maxahead) maxahead = nreq - nhs;
      if (axi_rd_done) begin
        ndone++;
        chk({v.name, ":done_on_last"}, RVALID && RREADY && RLAST, 1);
      end
      if (RVALID && first_rv < 0) first_rv = k;
      if (RVALID && RREADY) begin
        exp_d = (v.exp_resp == 2'b00) ? {8'hA5, tag, 5'b00000, ((beat < 8) ? v.exp_addr[beat] : 11'h7FF)}
                                      : 32'h0;
        chk({v.name, ":rdata"}, RDATA, exp_d);
        chk({v.name, ":rresp"}, RRESP, v.exp_resp);
        chk({v.name, ":rlast"}, RLAST, (beat == int'(v.len)));
        chk({v.name, ":rid"}, RID, v.id);
        beat++; nhs++;
        if (RLAST) fin = 1;
        if (abort_beats > 0 && beat == abort_beats) fin = 1;
      end
      prev_stall = RVALID && !RREADY;
      held_d = RDATA; held_resp = RRESP; held_last = RLAST;
    end
    chk({v.name, ":burst_ended"}, fin, 1);
    chk({v.name, ":first_rvalid_cycle"}, first_rv, 3);
    chk({v.name, ":max_ahead_le2"}, (maxahead <= 2), 1);
    if (abort_beats == 0) begin
      chk({v.name, ":beats"}, beat, int'(v.len) + 1);
      chk({v.name, ":nreq"}, nreq, v.exp_nreq);
      chk({v.name, ":done_count"}, ndone, 1);
      @(negedge clk); RREADY = 1'b1; #1;
      chk({v.name, ":arready_after_last"}, ARREADY, 1);
      chk({v.name, ":rvalid_idle"}, RVALID, 0);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ":arready"}, ARREADY, 0);
    chk({nm, ":rvalid"}, RVALID, 0);
    chk({nm, ":rlast"}, RLAST, 0);
    chk({nm, ":rdata"}, RDATA, 0);
    chk({nm, ":rid"}, RID, 0);
    chk({nm, ":rresp"}, RRESP, 0);
    chk({nm, ":req"}, axi_rd_req, 0);
    chk({nm, ":addr"}, axi_rd_addr, 0);
    chk({nm, ":region"}, axi_rd_region, 0);
    chk({nm, ":done"}, axi_rd_done, 0);
  endtask

  initial begin
    // expected address lists are written last beat first
    vecs[0]  = mk("incr4", 8'h3C, 11'h000, 8'd3, 3'd2, 2'b01, 4'd2, 2'b00, 4,
                  {11'h0, 11'h0, 11'h0, 11'h0, 11'h00C, 11'h008, 11'h004, 11'h000});
    vecs[1]  = mk("wrap4", 8'h11, 11'h008, 8'd3, 3'd2, 2'b10, 4'd1, 2'b00, 4,
                  {11'h0, 11'h0, 11'h0, 11'h0, 11'h004, 11'h000, 11'h00C, 11'h008});
    vecs[2]  = mk("incr_top", 8'h22, 11'h7FC, 8'd1, 3'd2, 2'b01, 4'd0, 2'b00, 2,
                  {11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 11'h000, 11'h7FC});
    vecs[3]  = mk("backpress", 8'h33, 11'h100, 8'd7, 3'd2, 2'b01, 4'd2, 2'b00, 8,
                  {11'h11C, 11'h118, 11'h114, 11'h110, 11'h10C, 11'h108, 11'h104, 11'h100});
    vecs[4]  = mk("err_region", 8'h44, 11'h020, 8'd2, 3'd2, 2'b01, 4'd5, 2'b10, 0, '0);
    vecs[5]  = mk("err_burst11", 8'h55, 11'h020, 8'd2, 3'd2, 2'b11, 4'd0, 2'b10, 0, '0);
    vecs[6]  = mk("err_wraplen", 8'h66, 11'h020, 8'd2, 3'd2, 2'b10, 4'd1, 2'b10, 0, '0);
    vecs[7]  = mk("err_size", 8'h67, 11'h020, 8'd0, 3'd3, 2'b01, 4'd1, 2'b10, 0, '0);
    vecs[8]  = mk("fixed1", 8'h77, 11'h040, 8'd0, 3'd2, 2'b00, 4'd0, 2'b00, 1,
                  {11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 11'h040});
    vecs[9]  = mk("abort", 8'h88, 11'h200, 8'd7, 3'd2, 2'b01, 4'd1, 2'b00, 8,
                  {11'h21C, 11'h218, 11'h214, 11'h210, 11'h20C, 11'h208, 11'h204, 11'h200});
    vecs[10] = mk("post_rst", 8'h99, 11'h010, 8'd3, 3'd1, 2'b01, 4'd2, 2'b00, 4,
                  {11'h0, 11'h0, 11'h0, 11'h0, 11'h016, 11'h014, 11'h012, 11'h010});

    tag = 8'h10;
    rst = 1'b1; ARVALID = 1'b0; RREADY = 1'b1;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARREGION = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    #1;
    chk("arready_low_at_release", ARREADY, 0);
    @(negedge clk); #1;
    chk("arready_after_release", ARREADY, 1);

    // table of single bursts
    for (int i = 0; i < 8; i++) begin
      tag = 8'h10 + 8'(i);
      run_vec(i, (i == 3) ? 1 : 0, 1'b0, 0);
    end

    // back-to-back: ARVALID held through the first FIXED single-beat burst
    tag = 8'h40;
    run_vec(8, 0, 1'b1, 0);
    run_vec(8, 0, 1'b0, 0);

    // reset after two beats of an 8-beat burst
    tag = 8'h50;
    run_vec(9, 0, 1'b0, 2);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_arready_low", ARREADY, 0);
    @(negedge clk); #1;
    chk("mid_rst_arready_up", ARREADY, 1);
    chk("mid_rst_no_stale", RVALID, 0);
    tag = 8'h60;
    run_vec(10, 0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
